// File: rtl/frame_acc_pkg.sv
// Shared types and constants for the frame accumulator slice.
package frame_acc_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam int WORD_W    = 32;
    localparam int ACC_W_DEF = 48;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/adder33.sv
// 32-bit ripple-carry adder with carry in/out (33-bit result).
module adder33
    import frame_acc_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              carry_out
);

    logic [WORD_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WORD_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry_out = c[WORD_W];

endmodule

// File: rtl/frame_accumulator.sv
// Sums a valid/ready stream of 32-bit words per frame; the low word goes
// through adder33 and its carry bumps the upper accumulator bits.
module frame_accumulator
    import frame_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int HI_W = ACC_W - WORD_W;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic [WORD_W-1:0]   lo_sum;
    logic                cout;
    logic                accept;

    adder33 u_lo_add (
        .a         (acc_q[WORD_W-1:0]),
        .b         (in_data),
        .cin       (1'b0),
        .sum       (lo_sum),
        .carry_out (cout)
    );

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_ACC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (accept && in_last) state_d = ST_DONE;
            ST_DONE: if (out_ready)         state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_DONE);
    end

    // Overflow is judged on the high word before the increment wraps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
            if (out_ready) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end
        end else if (accept) begin
            acc_q <= {acc_q[ACC_W-1:WORD_W] + HI_W'(cout), lo_sum};
            cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            ovf_q <= ovf_q | (cout & (&acc_q[ACC_W-1:WORD_W]));
        end
    end

    assign out_sum      = acc_q;
    assign out_count    = cnt_q;
    assign out_overflow = ovf_q;

endmodule
